// File: rtl/dmem_pkg.sv
// Shared types for the data memory and its posted-store buffer.
package dmem_pkg;

  localparam int unsigned SB_ADDR_W = 8;
  localparam int unsigned SB_DATA_W = 32;

  typedef enum logic [1:0] {
    SB_BYTE = 2'b00,
    SB_HALF = 2'b01,
    SB_WORD = 2'b10,
    SB_RSVD = 2'b11
  } sb_mode_e;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    sb_mode_e             mode;
  } sb_entry_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] lane;
  } cover_t;

  // Offset is taken modulo the address space so stores wrapping past the top still match.
  function automatic cover_t byte_cover(input logic [SB_ADDR_W-1:0] entry_addr,
                                        input sb_mode_e             mode,
                                        input logic [SB_ADDR_W-1:0] byte_addr);
    logic [SB_ADDR_W-1:0] off;
    cover_t               c;
    off    = byte_addr - entry_addr;
    c.lane = off[1:0];
    case (mode)
      SB_BYTE: c.hit = (off == '0);
      SB_HALF: c.hit = (off < SB_ADDR_W'(2));
      SB_WORD: c.hit = (off < SB_ADDR_W'(4));
      default: c.hit = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Store-buffer FIFO; exposes its entries oldest-first with a matching valid vector.
module sb_fifo
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  sb_entry_t                  push_entry,
  output sb_entry_t                  entries [DEPTH],
  output logic [DEPTH-1:0]           valid,
  output sb_entry_t                  head_entry,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  sb_entry_t         mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      entries[k] = mem[head + PW'(k)];
      valid[k]   = (CW'(k) < count);
    end
    head_entry = mem[head];
  end

endmodule

// File: rtl/dmem_sb.sv
// Byte-addressed data memory behind a posted-store buffer with byte-granular load forwarding.
module dmem_sb
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W   = SB_ADDR_W,
  parameter int unsigned DATA_W   = SB_DATA_W,
  parameter int unsigned MEM_S    = 256,
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned STORE_M  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [STORE_M-1:0]          mode,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        rd_en,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        sb_full,
  output logic                        sb_empty,
  output logic [$clog2(SB_DEPTH):0]   sb_count
);

  localparam int unsigned CW = $clog2(SB_DEPTH) + 1;

  logic [7:0]        ram [MEM_S];
  logic              push;
  logic              pop;
  sb_entry_t         new_entry;
  sb_entry_t         head_entry;
  sb_entry_t         entries [SB_DEPTH];
  logic [SB_DEPTH-1:0] valid;
  logic [ADDR_W-1:0] lane_addr [4];
  logic [3:0]        lane_we;

  assign sb_full   = (sb_count == CW'(SB_DEPTH));
  assign sb_empty  = (sb_count == '0);
  // Both decisions use the pre-edge count: a pop never frees a slot for a same-cycle push.
  assign push      = wr_en && (mode != SB_RSVD) && !sb_full;
  assign pop       = !sb_empty && (!rd_en || sb_full);
  assign new_entry = '{addr: wr_addr, data: wr_data, mode: sb_mode_e'(mode)};

  sb_fifo #(.DEPTH(SB_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .push_entry (new_entry),
    .entries    (entries),
    .valid      (valid),
    .head_entry (head_entry),
    .count      (sb_count)
  );

  always_comb begin
    cover_t c;
    for (int unsigned k = 0; k < 4; k++) begin
      lane_addr[k] = head_entry.addr + ADDR_W'(k);
      c            = byte_cover(head_entry.addr, head_entry.mode, lane_addr[k]);
      lane_we[k]   = pop && c.hit;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 4; k++) begin
      if (lane_we[k]) ram[lane_addr[k]] <= head_entry.data[8*k +: 8];
    end
  end

  // Entries are scanned oldest-first, so the last hit is the youngest covering store.
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [7:0]        b;
    cover_t            c;
    rd_data = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      a = rd_addr + ADDR_W'(i);
      b = ram[a];
      for (int unsigned k = 0; k < SB_DEPTH; k++) begin
        c = byte_cover(entries[k].addr, entries[k].mode, a);
        if (valid[k] && c.hit) b = entries[k].data[8*c.lane +: 8];
      end
      rd_data[8*i +: 8] = b;
    end
  end

endmodule

// File: tb/tb_dmem_sb.sv
// Scoreboard bench for dmem_sb: stimulus queues expectations, a negedge monitor checks them.
module tb_dmem_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  wr_addr = '0;
  logic [7:0]  rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        sb_full;
  logic        sb_empty;
  logic [2:0]  sb_count;

  localparam int K_RD = 0, K_CNT = 1, K_FULL = 2, K_EMPTY = 3;

  typedef struct {
    int          cyc;
    int          what;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  dmem_sb #(
    .ADDR_W   (8),
    .DATA_W   (32),
    .MEM_S    (256),
    .SB_DEPTH (4),
    .STORE_M  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .mode     (mode),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .sb_full  (sb_full),
    .sb_empty (sb_empty),
    .sb_count (sb_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      case (e.what)
        K_RD:    act = rd_data;
        K_CNT:   act = {29'b0, sb_count};
        K_FULL:  act = {31'b0, sb_full};
        default: act = {31'b0, sb_empty};
      endcase
      checks++;
      if (e.cyc != cyc || act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc);
      end
    end
  end

  task automatic chk(input int what, input logic [31:0] exp, input string name);
    exp_t e;
    e.cyc = cyc; e.what = what; e.exp = exp; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [1:0] m, input logic [7:0] a, input logic [31:0] d);
    wr_en = 1'b1; mode = m; wr_addr = a; wr_data = d;
  endtask

  task automatic idle();
    wr_en = 1'b0;
  endtask

  task automatic ld(input logic [7:0] a, input logic [31:0] e, input string name);
    rd_addr = a;
    chk(K_RD, e, name);
  endtask

  task automatic drain();
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    step(); step();
    chk(K_CNT, 0, "rst_count"); chk(K_EMPTY, 1, "rst_empty"); chk(K_FULL, 0, "rst_full");
    rst = 1'b0;

    // word store, idle drain
    step(); st(2'b10, 8'h10, 32'h11223344); chk(K_CNT, 0, "t1_pre_push");
    step(); idle(); chk(K_CNT, 1, "t1_pushed"); ld(8'h10, 32'h11223344, "t1_fwd");
    step(); chk(K_CNT, 0, "t1_drained"); chk(K_EMPTY, 1, "t1_empty"); ld(8'h10, 32'h11223344, "t1_ram");

    // mixed-size forwarding with rd_en held
    step(); rd_en = 1'b1; st(2'b10, 8'h20, 32'hAABBCCDD);
    step(); st(2'b00, 8'h21, 32'h0000005A); chk(K_CNT, 1, "t2_one");
    ld(8'h20, 32'hAABBCCDD, "t2_same_cycle_not_fwd");
    step(); idle(); chk(K_CNT, 2, "t2_two"); chk(K_FULL, 0, "t2_not_full");
    ld(8'h20, 32'hAABB5ADD, "t2_fwd_youngest");
    step(); chk(K_CNT, 2, "t2_no_drain");
    drain(); ld(8'h20, 32'hAABB5ADD, "t2_ram"); chk(K_EMPTY, 1, "t2_empty");

    // fill to full, forced drain, dropped fifth store
    st(2'b10, 8'h44, 32'hCAFEF00D);
    step(); idle();
    step();
    rd_en = 1'b1; st(2'b00, 8'h40, 32'h01);
    step(); chk(K_CNT, 1, "t3_c1"); st(2'b00, 8'h41, 32'h02);
    step(); chk(K_CNT, 2, "t3_c2"); st(2'b00, 8'h42, 32'h03);
    step(); chk(K_CNT, 3, "t3_c3"); st(2'b00, 8'h43, 32'h04);
    step(); chk(K_CNT, 4, "t3_c4"); chk(K_FULL, 1, "t3_full");
    ld(8'h40, 32'h04030201, "t3_fwd4"); st(2'b00, 8'h44, 32'h55);
    step(); idle(); chk(K_CNT, 3, "t3_c5"); chk(K_FULL, 0, "t3_not_full");
    drain(); ld(8'h41, 32'h0D040302, "t3_fifth_dropped");

    // wrap-around half store over a buffered word
    rd_en = 1'b1; st(2'b10, 8'hFE, 32'h04030201);
    step(); st(2'b01, 8'hFF, 32'h0000BEEF);
    step(); idle(); chk(K_CNT, 2, "t4_two"); ld(8'hFE, 32'h04BEEF01, "t4_fwd_wrap");
    drain(); ld(8'hFE, 32'h04BEEF01, "t4_ram_wrap");

    // reserved mode is dropped
    st(2'b10, 8'h30, 32'h76543210);
    step(); idle();
    step(); st(2'b11, 8'h30, 32'hFFFFFFFF); chk(K_CNT, 0, "t5_pre");
    step(); idle(); chk(K_CNT, 0, "t5_dropped"); chk(K_EMPTY, 1, "t5_empty");
    ld(8'h30, 32'h76543210, "t5_ram_same");
    step(); ld(8'h30, 32'h76543210, "t5_ram_later");

    // async reset discards buffered stores
    rd_en = 1'b1; st(2'b10, 8'h10, 32'hDEADBEEF);
    step(); st(2'b00, 8'h22, 32'h99);
    step(); st(2'b01, 8'h12, 32'h7777);
    step(); idle(); chk(K_CNT, 3, "t6_three"); ld(8'h10, 32'h7777BEEF, "t6_fwd");
    step(); chk(K_CNT, 3, "t6_hold"); ld(8'h20, 32'hAA995ADD, "t6_fwd_byte");
    step(); rst = 1'b1;
    chk(K_CNT, 0, "t6_rst_count"); chk(K_EMPTY, 1, "t6_rst_empty"); chk(K_FULL, 0, "t6_rst_full");
    ld(8'h10, 32'h11223344, "t6_ram10");
    step(); ld(8'h20, 32'hAABB5ADD, "t6_ram20");
    step(); rst = 1'b0;
    step(); chk(K_EMPTY, 1, "t6_post_empty"); ld(8'h10, 32'h11223344, "t6_post_ram10");

    step(); step();
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
